// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RV32 subset instruction decode with ID/EX pipeline register,
//            writeback bypass, load-use stall detection and bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        ValidD,
  output logic [4:0]  A1,
  output logic [4:0]  A2,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  input  logic        FlushE,
  output logic        StallD,
  output logic        ValidE,
  output logic [31:0] InstrE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        ALUSrcE,
  output logic        BranchE,
  output logic        JumpE,
  output logic [2:0]  ALUControlE,
  output logic        IllegalE,
  output logic [15:0] BubbleCount
);

  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_LUI  = 7'b0110111;
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  resultsrc;
    logic        alusrc;
    logic        branch;
    logic        jump;
    logic [2:0]  aluctl;
    logic        illegal;
  } idex_t;

  idex_t       idex_d, idex_q, w_slot, w_bubble;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [2:0]  w_alu_f3;
  logic        w_f3_ok;
  logic        w_rs1_used, w_rs2_used;
  logic        w_hazard, w_load_bubble, w_count;
  logic [31:0] w_op1, w_op2;

  assign w_opcode = InstrD[6:0];
  assign w_funct3 = InstrD[14:12];
  assign A1       = InstrD[19:15];
  assign A2       = InstrD[24:20];
  assign WE3      = RegWriteW;
  assign A3       = RdW;
  assign WD3      = ResultW;

  // Writeback bypass: a same-cycle write to a source register wins over the file
  assign w_op1 = (RegWriteW && (RdW != 5'd0) && (RdW == A1)) ? ResultW : RD1;
  assign w_op2 = (RegWriteW && (RdW != 5'd0) && (RdW == A2)) ? ResultW : RD2;

  // ALU operation selected by funct3 for R-type and I-ALU instructions
  always_comb begin
    w_alu_f3 = 3'b000;
    w_f3_ok  = 1'b1;
    case (w_funct3)
      3'b000:  w_alu_f3 = ((w_opcode == c_OP_R) && InstrD[30]) ? 3'b001 : 3'b000;
      3'b010:  w_alu_f3 = 3'b101;
      3'b110:  w_alu_f3 = 3'b011;
      3'b111:  w_alu_f3 = 3'b010;
      default: w_f3_ok  = 1'b0;
    endcase
  end

  // Decode the IF/ID slot into the full ID/EX payload
  always_comb begin
    w_slot       = '0;
    w_slot.valid = 1'b1;
    w_slot.instr = InstrD;
    w_slot.pc    = PCD;
    w_slot.pcp4  = PCPlus4D;
    w_slot.rd1   = w_op1;
    w_slot.rd2   = w_op2;
    w_rs1_used   = 1'b0;
    w_rs2_used   = 1'b0;
    case (w_opcode)
      c_OP_LW: begin
        w_slot.regwrite  = 1'b1;
        w_slot.resultsrc = 2'b01;
        w_slot.alusrc    = 1'b1;
        w_slot.imm       = {{20{InstrD[31]}}, InstrD[31:20]};
        w_rs1_used       = 1'b1;
      end
      c_OP_SW: begin
        w_slot.memwrite = 1'b1;
        w_slot.alusrc   = 1'b1;
        w_slot.imm      = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
        w_rs1_used      = 1'b1;
        w_rs2_used      = 1'b1;
      end
      c_OP_R: begin
        w_slot.regwrite = 1'b1;
        w_slot.aluctl   = w_alu_f3;
        w_slot.illegal  = ~w_f3_ok;
        w_rs1_used      = 1'b1;
        w_rs2_used      = 1'b1;
      end
      c_OP_I: begin
        w_slot.regwrite = 1'b1;
        w_slot.alusrc   = 1'b1;
        w_slot.aluctl   = w_alu_f3;
        w_slot.imm      = {{20{InstrD[31]}}, InstrD[31:20]};
        w_slot.illegal  = ~w_f3_ok;
        w_rs1_used      = 1'b1;
      end
      c_OP_BEQ: begin
        w_slot.branch = 1'b1;
        w_slot.aluctl = 3'b001;
        w_slot.imm    = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                         InstrD[11:8], 1'b0};
        w_rs1_used    = 1'b1;
        w_rs2_used    = 1'b1;
      end
      c_OP_JAL: begin
        w_slot.regwrite  = 1'b1;
        w_slot.jump      = 1'b1;
        w_slot.resultsrc = 2'b10;
        w_slot.imm       = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                            InstrD[30:21], 1'b0};
      end
      c_OP_LUI: begin
        w_slot.regwrite = 1'b1;
        w_slot.alusrc   = 1'b1;
        w_slot.rd1      = 32'd0;
        w_slot.imm      = {InstrD[31:12], 12'd0};
      end
      default: w_slot.illegal = 1'b1;
    endcase
    // An illegal instruction keeps its slot but performs no architectural action
    if (w_slot.illegal) begin
      w_slot.regwrite  = 1'b0;
      w_slot.memwrite  = 1'b0;
      w_slot.branch    = 1'b0;
      w_slot.jump      = 1'b0;
      w_slot.resultsrc = 2'b00;
      w_slot.alusrc    = 1'b0;
      w_slot.aluctl    = 3'b000;
      w_slot.imm       = 32'd0;
      w_rs1_used       = 1'b0;
      w_rs2_used       = 1'b0;
    end
    // Unused register fields read as x0 so later forwarding never matches them
    w_slot.rs1 = w_rs1_used      ? InstrD[19:15] : 5'd0;
    w_slot.rs2 = w_rs2_used      ? InstrD[24:20] : 5'd0;
    w_slot.rd  = w_slot.regwrite ? InstrD[11:7]  : 5'd0;
  end

  assign w_hazard = idex_q.valid && (idex_q.resultsrc == 2'b01) && (idex_q.rd != 5'd0)
                    && ValidD
                    && (((idex_q.rd == A1) && w_rs1_used) || ((idex_q.rd == A2) && w_rs2_used));
  assign StallD        = w_hazard & ~FlushE;
  assign w_count       = StallD | FlushE;
  assign w_load_bubble = w_count | ~ValidD;

  // Select bubble or decoded slot for the ID/EX register; saturating bubble count
  always_comb begin
    w_bubble       = '0;
    w_bubble.instr = NOP_INSTR;
    idex_d         = w_load_bubble ? w_bubble : w_slot;
    bubble_cnt_d   = (w_count && (bubble_cnt_q != c_CNT_MAX)) ? bubble_cnt_q + 16'd1
                                                               : bubble_cnt_q;
  end

  // ID/EX pipeline register and bubble counter, reset loads a bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_q       <= w_bubble;
      bubble_cnt_q <= 16'd0;
    end else begin
      idex_q       <= idex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ValidE      = idex_q.valid;
  assign InstrE      = idex_q.instr;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pcp4;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign RegWriteE   = idex_q.regwrite;
  assign MemWriteE   = idex_q.memwrite;
  assign ResultSrcE  = idex_q.resultsrc;
  assign ALUSrcE     = idex_q.alusrc;
  assign BranchE     = idex_q.branch;
  assign JumpE       = idex_q.jump;
  assign ALUControlE = idex_q.aluctl;
  assign IllegalE    = idex_q.illegal;
  assign BubbleCount = bubble_cnt_q;

endmodule
`default_nettype wire
